// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, FSM states and collision cause encoding for the snake collision engine
package snake_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int LEN_W_DEF   = 6;
  localparam int MAX_LEN_DEF = 63;
  localparam int GRID_W_DEF  = 136;
  localparam int GRID_H_DEF  = 76;
  localparam int LIVES_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SCAN,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_WALL,
    CAUSE_SELF
  } cause_t;

endpackage

// File: rtl/snake_body_scanner.sv
// rtl/snake_body_scanner.sv - walks body segments 1..len-1 through a 1-cycle RAM port, aborting on first head match
module snake_body_scanner
  import snake_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_go,
  input  logic [LEN_W-1:0]   len,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] seg_x,
  input  logic [COORD_W-1:0] seg_y,
  output logic               seg_rd_en,
  output logic [LEN_W-1:0]   seg_addr,
  output logic               scan_hit,
  output logic               scan_end
);

  logic active;
  logic cmp_valid;
  logic cmp_last;
  logic last_addr;

  assign last_addr = (seg_addr == len - LEN_W'(1));
  assign scan_hit  = cmp_valid && (seg_x == head_x) && (seg_y == head_y);
  assign scan_end  = cmp_valid && cmp_last;
  // A match suppresses the read already queued for this cycle
  assign seg_rd_en = active && !scan_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_last  <= 1'b0;
      seg_addr  <= '0;
    end else if (scan_go) begin
      active    <= 1'b1;
      cmp_valid <= 1'b0;
      cmp_last  <= 1'b0;
      seg_addr  <= LEN_W'(1);
    end else begin
      cmp_valid <= seg_rd_en;
      cmp_last  <= seg_rd_en && last_addr;
      if (scan_hit) begin
        active <= 1'b0;
      end else if (active) begin
        if (last_addr) active <= 1'b0;
        else seg_addr <= seg_addr + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_collision_engine.sv
// rtl/snake_collision_engine.sv - multi-cycle head check: boundary rules, body scan, food, lives/length/respawn
module snake_collision_engine
  import snake_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int LIVES_W   = LIVES_W_DEF,
  parameter int WRAP_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic [LEN_W-1:0]   snake_length,
  input  logic [LIVES_W-1:0] lives_in,
  input  logic [23:0]        rnd,
  output logic               seg_rd_en,
  output logic [LEN_W-1:0]   seg_addr,
  input  logic [COORD_W-1:0] seg_x,
  input  logic [COORD_W-1:0] seg_y,
  output logic               busy,
  output logic               done,
  output logic               hit_wall,
  output logic               hit_self,
  output logic               ate_food,
  output logic               game_over,
  output logic [LIVES_W-1:0] lives_out,
  output logic [LEN_W-1:0]   length_out,
  output logic [COORD_W-1:0] new_head_x,
  output logic [COORD_W-1:0] new_head_y
);

  localparam logic [COORD_W-1:0] GW = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GH = COORD_W'(GRID_H);

  state_t state, state_nx;
  cause_t cause;

  logic [COORD_W-1:0] hx, hy, fx, fy, wx, wy;
  logic [LEN_W-1:0]   len_r;
  logic [LIVES_W-1:0] lives_r;
  logic               wall, wall_hit, self_r;
  logic               scan_go, scan_hit, scan_end;
  logic [11:0]        spawn_x, spawn_y;
  logic [LEN_W:0]     len_inc;

  always_comb begin
    wall     = (hx == '0) || (hx >= GW) || (hy == '0) || (hy >= GH);
    wall_hit = (WRAP_MODE == 0) && wall;
    wx = hx;
    wy = hy;
    if (WRAP_MODE != 0) begin
      if (hx == '0) wx = GW - COORD_W'(1);
      else if (hx >= GW) wx = COORD_W'(1);
      if (hy == '0) wy = GH - COORD_W'(1);
      else if (hy >= GH) wy = COORD_W'(1);
    end
    if (wall_hit) cause = CAUSE_WALL;
    else if (self_r) cause = CAUSE_SELF;
    else cause = CAUSE_NONE;
    // Respawn stays two blocks clear of every edge
    spawn_x = (rnd[11:0] % 12'(GRID_W - 4)) + 12'd2;
    spawn_y = (rnd[23:12] % 12'(GRID_H - 4)) + 12'd2;
    len_inc = {1'b0, len_r} + (LEN_W+1)'(1);
  end

  always_comb begin
    state_nx = state;
    scan_go  = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (wall_hit || len_r == LEN_W'(1)) begin
          state_nx = ST_RESOLVE;
        end else begin
          state_nx = ST_SCAN;
          scan_go  = 1'b1;
        end
      end
      ST_SCAN:    if (scan_hit || scan_end) state_nx = ST_RESOLVE;
      ST_RESOLVE: state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hx         <= '0;
      hy         <= '0;
      fx         <= '0;
      fy         <= '0;
      len_r      <= '0;
      lives_r    <= '0;
      self_r     <= 1'b0;
      hit_wall   <= 1'b0;
      hit_self   <= 1'b0;
      ate_food   <= 1'b0;
      game_over  <= 1'b0;
      lives_out  <= '0;
      length_out <= '0;
      new_head_x <= '0;
      new_head_y <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        hx        <= head_x;
        hy        <= head_y;
        fx        <= food_x;
        fy        <= food_y;
        len_r     <= snake_length;
        lives_r   <= lives_in;
        self_r    <= 1'b0;
        hit_wall  <= 1'b0;
        hit_self  <= 1'b0;
        ate_food  <= 1'b0;
        game_over <= 1'b0;
      end
      if (state == ST_SCAN && scan_hit) self_r <= 1'b1;
      if (state == ST_RESOLVE) begin
        new_head_x <= wx;
        new_head_y <= wy;
        lives_out  <= lives_r;
        length_out <= len_r;
        if (cause != CAUSE_NONE) begin
          hit_wall   <= (cause == CAUSE_WALL);
          hit_self   <= (cause == CAUSE_SELF);
          lives_out  <= (lives_r == '0) ? '0 : lives_r - LIVES_W'(1);
          length_out <= LEN_W'(1);
          if (lives_r <= LIVES_W'(1)) begin
            game_over <= 1'b1;
          end else begin
            new_head_x <= COORD_W'(spawn_x);
            new_head_y <= COORD_W'(spawn_y);
          end
        end else if (wx == fx && wy == fy) begin
          ate_food   <= 1'b1;
          length_out <= (len_inc > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_inc[LEN_W-1:0];
        end
      end
    end
  end

  snake_body_scanner #(
    .COORD_W(COORD_W),
    .LEN_W  (LEN_W)
  ) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .scan_go  (scan_go),
    .len      (len_r),
    .head_x   (wx),
    .head_y   (wy),
    .seg_x    (seg_x),
    .seg_y    (seg_y),
    .seg_rd_en(seg_rd_en),
    .seg_addr (seg_addr),
    .scan_hit (scan_hit),
    .scan_end (scan_end)
  );

endmodule

// File: tb/tb_snake_collision_engine.sv
// tb/tb_snake_collision_engine.sv - self-checking bench: wall-kill and wrap instances against a reference model
module tb_snake_collision_engine;

  typedef struct {
    int cyc, flags, lives, len, nx, ny, reads;
  } exp_t;

  typedef struct {
    int m, hx, hy, fx, fy, len, lv, rn, k;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] head_x, head_y, food_x, food_y;
  logic [5:0]  snake_length;
  logic [2:0]  lives_in;
  logic [23:0] rnd;

  logic        seg_rd_en [2];
  logic [5:0]  seg_addr [2];
  logic [10:0] seg_x [2], seg_y [2];
  logic        busy [2], done [2], hit_wall [2], hit_self [2], ate_food [2], game_over [2];
  logic [2:0]  lives_out [2];
  logic [5:0]  length_out [2];
  logic [10:0] new_head_x [2], new_head_y [2];

  logic [10:0] mem_x [64], mem_y [64];

  int   n_tests = 0, n_fail = 0;
  int   r_cyc [2], r_flags [2], r_lives [2], r_len [2], r_nx [2], r_ny [2], r_reads [2], r_rdok [2];
  vec_t tbl [9];

  always #5 clk = ~clk;

  snake_collision_engine #(.WRAP_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .head_x(head_x), .head_y(head_y),
    .food_x(food_x), .food_y(food_y), .snake_length(snake_length), .lives_in(lives_in), .rnd(rnd),
    .seg_rd_en(seg_rd_en[0]), .seg_addr(seg_addr[0]), .seg_x(seg_x[0]), .seg_y(seg_y[0]),
    .busy(busy[0]), .done(done[0]), .hit_wall(hit_wall[0]), .hit_self(hit_self[0]),
    .ate_food(ate_food[0]), .game_over(game_over[0]), .lives_out(lives_out[0]),
    .length_out(length_out[0]), .new_head_x(new_head_x[0]), .new_head_y(new_head_y[0])
  );

  snake_collision_engine #(.WRAP_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .head_x(head_x), .head_y(head_y),
    .food_x(food_x), .food_y(food_y), .snake_length(snake_length), .lives_in(lives_in), .rnd(rnd),
    .seg_rd_en(seg_rd_en[1]), .seg_addr(seg_addr[1]), .seg_x(seg_x[1]), .seg_y(seg_y[1]),
    .busy(busy[1]), .done(done[1]), .hit_wall(hit_wall[1]), .hit_self(hit_self[1]),
    .ate_food(ate_food[1]), .game_over(game_over[1]), .lives_out(lives_out[1]),
    .length_out(length_out[1]), .new_head_x(new_head_x[1]), .new_head_y(new_head_y[1])
  );

  // Body RAM: registered read, one per instance
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (seg_rd_en[d]) begin
        seg_x[d] <= mem_x[seg_addr[d]];
        seg_y[d] <= mem_y[seg_addr[d]];
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_out(input int d);
    return int'(|{seg_rd_en[d], seg_addr[d], busy[d], done[d], hit_wall[d], hit_self[d],
                  ate_food[d], game_over[d], lives_out[d], length_out[d], new_head_x[d], new_head_y[d]});
  endfunction

  task automatic fill_default();
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = 11'(1000 + i);
      mem_y[i] = 11'(1000 + i);
    end
  endtask

  function automatic exp_t model(input int mode, input int hx, input int hy, input int fx, input int fy,
                                 input int len, input int lv, input int rn);
    exp_t e;
    int wx, wy, k;
    bit wall, coll;
    wall = (hx == 0) || (hx >= 136) || (hy == 0) || (hy >= 76);
    wx = hx; wy = hy;
    if (mode == 1) begin
      if (hx == 0) wx = 135; else if (hx >= 136) wx = 1;
      if (hy == 0) wy = 75;  else if (hy >= 76)  wy = 1;
    end
    e.flags = 0; coll = 0; k = 0;
    if (wall && mode == 0) begin
      coll = 1; e.flags = 8; e.reads = 0; e.cyc = 3;
    end else if (len == 1) begin
      e.reads = 0; e.cyc = 3;
    end else begin
      for (int i = 1; i < len; i++) begin
        if (int'(mem_x[i]) == wx && int'(mem_y[i]) == wy) begin
          k = i;
          break;
        end
      end
      if (k != 0) begin
        coll = 1; e.flags = 4; e.reads = k; e.cyc = k + 4;
      end else begin
        e.reads = len - 1; e.cyc = len + 3;
      end
    end
    e.lives = lv; e.len = len; e.nx = wx; e.ny = wy;
    if (coll) begin
      e.lives = (lv > 0) ? lv - 1 : 0;
      e.len = 1;
      if (lv <= 1) begin
        e.flags = e.flags | 1;
      end else begin
        e.nx = ((rn & 'hfff) % 132) + 2;
        e.ny = (((rn >> 12) & 'hfff) % 72) + 2;
      end
    end else if (wx == fx && wy == fy) begin
      e.flags = 2;
      e.len = (len + 1 > 63) ? 63 : len + 1;
    end
    return e;
  endfunction

  task automatic cmp_all(input string tag, input int d, input exp_t e);
    check($sformatf("%s dut%0d done_cycle", tag, d), r_cyc[d], e.cyc);
    check($sformatf("%s dut%0d flags", tag, d), r_flags[d], e.flags);
    check($sformatf("%s dut%0d lives", tag, d), r_lives[d], e.lives);
    check($sformatf("%s dut%0d length", tag, d), r_len[d], e.len);
    check($sformatf("%s dut%0d head_x", tag, d), r_nx[d], e.nx);
    check($sformatf("%s dut%0d head_y", tag, d), r_ny[d], e.ny);
    check($sformatf("%s dut%0d reads", tag, d), r_reads[d], e.reads);
    check($sformatf("%s dut%0d read_order", tag, d), r_rdok[d], 1);
  endtask

  // Starts one operation on both instances; optionally re-pulses start (with a different head) mid-flight
  task automatic run_op(input int hx, input int hy, input int fx, input int fy, input int len,
                        input int lv, input int rn, input int repulse);
    bit got [2];
    int cyc;
    @(negedge clk);
    head_x = 11'(hx); head_y = 11'(hy); food_x = 11'(fx); food_y = 11'(fy);
    snake_length = 6'(len); lives_in = 3'(lv); rnd = 24'(rn); start = 1'b1;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      got[d] = 1'b0; r_reads[d] = 0; r_rdok[d] = 1; r_cyc[d] = -1;
    end
    while (!(got[0] && got[1]) && cyc < 150) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = (cyc == repulse);
      if (cyc == repulse) head_x = head_x + 11'd3;
      for (int d = 0; d < 2; d++) begin
        if (!got[d]) begin
          if (seg_rd_en[d]) begin
            if (int'(seg_addr[d]) != r_reads[d] + 1) r_rdok[d] = 0;
            r_reads[d]++;
          end
          if (done[d]) begin
            got[d] = 1'b1;
            r_cyc[d] = cyc;
            r_flags[d] = int'({hit_wall[d], hit_self[d], ate_food[d], game_over[d]});
            r_lives[d] = int'(lives_out[d]);
            r_len[d] = int'(length_out[d]);
            r_nx[d] = int'(new_head_x[d]);
            r_ny[d] = int'(new_head_y[d]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++)
      if (!got[d]) check($sformatf("dut%0d done_timeout", d), 0, 1);
  endtask

  initial begin
    exp_t e0, e1;
    int hx, hy, fx, fy, len, lv, rn, k;
    bit saw;

    tbl[0] = '{0,   0, 40,  5,  5,  5, 3, 'h00A014, 0, '{ 3, 8, 2,  1, 22, 12,  0}};
    tbl[1] = '{1, 136, 40,  1, 40,  1, 2, 0,        0, '{ 3, 2, 2,  2,  1, 40,  0}};
    tbl[2] = '{0,  50, 30,  7,  7,  6, 1, 'h123456, 3, '{ 7, 5, 0,  1, 50, 30,  3}};
    tbl[3] = '{0,  60, 20, 60, 20, 63, 2, 0,        0, '{66, 2, 2, 63, 60, 20, 62}};
    tbl[4] = '{0,  30, 30, 30, 30,  4, 3, 'h00A014, 2, '{ 6, 4, 2,  1, 22, 12,  2}};
    tbl[5] = '{0, 135, 75,  1,  1,  3, 0, 0,        0, '{ 6, 0, 0,  3,135, 75,  2}};
    tbl[6] = '{0,  10, 76, 10, 76,  5, 0, 0,        0, '{ 3, 9, 0,  1, 10, 76,  0}};
    tbl[7] = '{1,   5,  0,  5, 75,  1, 4, 0,        0, '{ 3, 2, 4,  2,  5, 75,  0}};
    tbl[8] = '{0, 136,  1,  9,  9,  7, 5, 'hFFFFFF, 0, '{ 3, 8, 4,  1,  5, 65,  0}};

    reset = 1'b1; start = 1'b0; head_x = '0; head_y = '0; food_x = '0; food_y = '0;
    snake_length = 6'd1; lives_in = '0; rnd = '0;
    fill_default();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("reset outputs dut%0d", d), all_out(d), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      fill_default();
      if (tbl[i].k != 0) begin
        mem_x[tbl[i].k] = 11'(tbl[i].hx);
        mem_y[tbl[i].k] = 11'(tbl[i].hy);
      end
      e0 = model(0, tbl[i].hx, tbl[i].hy, tbl[i].fx, tbl[i].fy, tbl[i].len, tbl[i].lv, tbl[i].rn);
      e1 = model(1, tbl[i].hx, tbl[i].hy, tbl[i].fx, tbl[i].fy, tbl[i].len, tbl[i].lv, tbl[i].rn);
      run_op(tbl[i].hx, tbl[i].hy, tbl[i].fx, tbl[i].fy, tbl[i].len, tbl[i].lv, tbl[i].rn, -1);
      cmp_all($sformatf("row%0d", i), tbl[i].m, tbl[i].e);
      cmp_all($sformatf("row%0d model", i), 0, e0);
      cmp_all($sformatf("row%0d model", i), 1, e1);
    end

    // start re-pulsed during SCAN must not recapture
    fill_default();
    e0 = model(0, 40, 40, 3, 3, 10, 3, 'h111111);
    e1 = model(1, 40, 40, 3, 3, 10, 3, 'h111111);
    run_op(40, 40, 3, 3, 10, 3, 'h111111, 4);
    cmp_all("repulse", 0, e0);
    cmp_all("repulse", 1, e1);

    // start held in the done cycle is ignored, accepted one cycle later
    run_op(20, 20, 1, 1, 1, 2, 0, -1);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("start_in_done ignored dut%0d busy", d), int'(busy[d]), 0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) check($sformatf("start after done accepted dut%0d busy", d), int'(busy[d]), 1);
    saw = 1'b0;
    for (int c = 0; c < 20 && !saw; c++) begin
      @(posedge clk); @(negedge clk);
      saw = done[0];
    end
    check("drain done seen", int'(saw), 1);

    // reset mid-scan, with a start re-pulse in flight
    @(negedge clk);
    head_x = 11'd40; head_y = 11'd41; food_x = 11'd3; food_y = 11'd3;
    snake_length = 6'd10; lives_in = 3'd3; rnd = 24'h0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0; reset = 1'b1;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midreset dut%0d busy", d), int'(busy[d]), 0);
      check($sformatf("midreset dut%0d outputs", d), all_out(d), 0);
    end
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (done[0] || done[1]) saw = 1'b1;
    end
    check("midreset no done", int'(saw), 0);

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      hx = $urandom_range(0, 140);
      hy = $urandom_range(0, 80);
      len = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(1, 16);
      lv = $urandom_range(0, 7);
      rn = int'($urandom & 32'h00FF_FFFF);
      if ($urandom_range(0, 2) == 0) begin
        fx = hx; fy = hy;
      end else begin
        fx = $urandom_range(1, 135); fy = $urandom_range(1, 75);
      end
      for (int i = 0; i < 64; i++) begin
        mem_x[i] = 11'($urandom_range(1, 135));
        mem_y[i] = 11'($urandom_range(1, 75));
      end
      if (len > 1 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, len - 1);
        mem_x[k] = 11'(hx);
        mem_y[k] = 11'(hy);
      end
      e0 = model(0, hx, hy, fx, fy, len, lv, rn);
      e1 = model(1, hx, hy, fx, fy, len, lv, rn);
      run_op(hx, hy, fx, fy, len, lv, rn, -1);
      cmp_all($sformatf("rand%0d", n), 0, e0);
      cmp_all($sformatf("rand%0d", n), 1, e1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_collision_engine.md
# snake_collision_engine

Parametrised, multi-cycle successor to the snake collision checker. On a `start` pulse it captures the new head position. It applies either wall-kill or wrap-around boundary rules. It scans the body through a 1-cycle-latency segment RAM read port, replacing the flat coordinate bus, and detects food pickup. It then resolves lives, length and respawn in one place, signalling completion with a `done` pulse. It sits between the movement/update logic and the game-state registers.

## Interface
- `COORD_W`, 11: coordinate width.
- `LEN_W`, 6: snake length width.
- `MAX_LEN`, 63: maximum length; growth saturates here.
- `GRID_W`, 136: playfield width in blocks.
- `GRID_H`, 76: playfield height in blocks.
- `LIVES_W`, 3: lives counter width.
- `WRAP_MODE`, 0: 0 = walls kill, 1 = edges wrap.
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; accepted only in IDLE.
- `head_x`, `head_y`  in  COORD_W: proposed head position.
- `food_x`, `food_y`  in  COORD_W: current food position.
- `snake_length`  in  LEN_W: current length, ≥1.
- `lives_in`  in  LIVES_W: current lives.
- `rnd`  in  24: free-running random word; [11:0] → x, [23:12] → y.
- `seg_rd_en`  out  1: body RAM read strobe.
- `seg_addr`  out  LEN_W: segment index.
- `seg_x`, `seg_y`  in  COORD_W: RAM data, valid the cycle after `seg_rd_en`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; result outputs valid from this cycle.
- `hit_wall`, `hit_self`, `ate_food`, `game_over`  out  1 each: result flags.
- `lives_out`  out  LIVES_W: resolved lives.
- `length_out`  out  LEN_W: resolved length.
- `new_head_x`, `new_head_y`  out  COORD_W: resolved head position.

## Operation
- FSM states: IDLE, CHECK, SCAN, RESOLVE, DONE.
- IDLE → CHECK on `start`; all inputs except `rnd`, `seg_*` are registered at acceptance.
- CHECK, one cycle:
  - Wall condition: x==0, x≥GRID_W, y==0 or y≥GRID_H.
  - WRAP_MODE=0: a wall condition sets `hit_wall`.
  - WRAP_MODE=1: remap x==0 → GRID_W-1, x≥GRID_W → 1, and likewise for y; `hit_wall` is never set.
  - Food compare uses the wrapped head.
  - → RESOLVE if `hit_wall` or length==1, else → SCAN.
- SCAN:
  - Issue `seg_addr` = 1, 2, …, length-1, one per cycle.
  - Compare the returned segment with the wrapped head the following cycle.
  - On the first match: set `hit_self`, stop issuing reads, → RESOLVE.
  - After the last compare with no match → RESOLVE.
  - Segment 0 (the old head) is never read.
- RESOLVE, one cycle. Priority is collision > food.
  - Collision (wall or self): `lives_out` = `lives_in`-1, saturating at 0; `length_out` = 1.
  - Collision with `lives_in` ≤ 1: `game_over` = 1, `new_head` = wrapped head.
  - Collision otherwise: `new_head_x` = (rnd[11:0] mod (GRID_W-4))+2 and `new_head_y` = (rnd[23:12] mod (GRID_H-4))+2, using `rnd` sampled this cycle.
  - No collision, head == food: `ate_food` = 1; `length_out` = min(length+1, MAX_LEN).
  - No collision, no food: pass-through of length, lives and wrapped head.
- DONE: pulse `done` for one cycle → IDLE.
- Flags and results hold until the next DONE. Flags are cleared on `start` acceptance.

## Timing
- Reset: state IDLE; every output 0, including `busy`, `done`, `seg_rd_en` and all flags.
- Start sampled at cycle 0; CHECK at cycle 1.
- Wall hit or length 1: RESOLVE at cycle 2, `done` at cycle 3.
- Full scan with no hit: addresses issued cycles 2..L; `done` at cycle L+3.
- Self hit at index k: `done` at cycle k+4; no `seg_rd_en` after cycle k+2.
- `start` while `busy` is ignored (no queueing).
- `start` in the `done` cycle is ignored. Earliest re-accept is the cycle after `done`.
- Reset mid-operation: IDLE next cycle; no `done` is produced; outputs are zeroed.
- Arithmetic:
  - mod operands are zero-extended to 12 bits.
  - +2 never exceeds the grid.
  - length+1 is computed at LEN_W+1 bits before saturation.

## Structure
- Shared package `snake_pkg`:
  - Grid, coordinate and length constants, defaulting the parameters.
  - FSM state enum.
  - 2-bit collision cause encoding: NONE, WALL, SELF, used for debug.
- One sub-module, `snake_body_scanner`:
  - Owns the address counter, read strobe, 1-cycle compare pipeline and early abort.
  - Handshake with the parent: `scan_go` / `scan_hit` / `scan_end`.
- Respawn modulo and wrap logic stay in the parent.

## Test plan
- WRAP_MODE=0, head (0,40), lives 3, len 5, rnd=0x00A_014:
  - `done` at cycle 3, `hit_wall`.
  - lives 2, length 1, new head (22,12).
  - No `seg_rd_en` ever.
- WRAP_MODE=1, head (136,40), len 1, food (1,40):
  - No `hit_wall`, new head (1,40), `ate_food`, length 2, `done` at cycle 3.
- Len 6, segment 3 equals head, lives 1:
  - Reads at addresses 1, 2, 3 only; `hit_self`, `game_over`.
  - lives 0, `done` at cycle 7.
- Len 63 = MAX_LEN, head on food, no body match:
  - 62 reads; length stays 63; `ate_food`; `done` at cycle 66.
- `start` re-pulsed during SCAN, then reset asserted mid-scan:
  - No second capture; `busy` low and all outputs 0 the cycle after reset.
  - No `done` pulse.
- Head on food and segment 2 simultaneously:
  - `hit_self`=1, `ate_food`=0, length 1.
